// File: rtl/seq_multiplier_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier_param
// Purpose  : Parametrised multi-cycle integer multiplier. Retires DIGIT
//            multiplier bits per CALC cycle, with unsigned or two's-complement
//            operands selected per operation. start/ready/done handshake,
//            state and iteration count exposed for debug.
// Ports    : clk         - rising-edge clock
//            reset       - synchronous active-high reset
//            start       - request, accepted only while ready=1
//            signed_mode - sampled with start; 1 = two's-complement a, b, p
//            a, b        - WIDTH-bit multiplicand / multiplier, sampled with start
//            ready       - high in IDLE only
//            p           - 2*WIDTH-bit product, valid from done until next start
//            done        - one-cycle pulse when p becomes valid
//            state_out   - current FSM state encoding
//            count_out   - CALC iteration index (0 outside CALC)
// Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier_param #(
    parameter int WIDTH = 128,
    parameter int DIGIT = 8,
    localparam int N    = WIDTH / DIGIT,
    localparam int CW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 done,
    output logic [1:0]           state_out,
    output logic [CW-1:0]        count_out
);

    localparam logic [1:0]    c_IDLE = 2'b00;
    localparam logic [1:0]    c_CALC = 2'b01;
    localparam logic [1:0]    c_SIGN = 2'b10;
    localparam logic [1:0]    c_DONE = 2'b11;
    localparam logic [CW-1:0] c_LAST = CW'(N - 1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [CW-1:0]          r_count;
    logic [WIDTH-1:0]       r_mag_a;
    logic [WIDTH-1:0]       r_b;
    logic                   r_signed;
    logic                   r_neg;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_p;

    logic                   w_last;
    logic [WIDTH-1:0]       w_abs_a;
    logic [WIDTH-1:0]       w_abs_b;
    logic [DIGIT-1:0]       w_digit;
    logic [WIDTH+DIGIT-1:0] w_pp;
    logic [2*WIDTH-1:0]     w_pp_shifted;

    // Magnitudes: -2^(W-1) negates to itself, which read as unsigned is
    // exactly 2^(W-1), so W bits are always enough.
    assign w_abs_a = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign w_abs_b = (signed_mode && b[WIDTH-1]) ? -b : b;

    assign w_last  = (r_count == c_LAST);

    // The multiplier register is shifted down each CALC cycle, so the
    // current digit always sits in the low bits.
    assign w_digit = r_b[DIGIT-1:0];
    assign w_pp    = {{DIGIT{1'b0}}, r_mag_a} * {{WIDTH{1'b0}}, w_digit};
    assign w_pp_shifted = (2*WIDTH)'(w_pp) << (32'(r_count) * DIGIT);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start)  w_state_nxt = c_CALC;
            c_CALC:  if (w_last) w_state_nxt = c_SIGN;
            c_SIGN:  w_state_nxt = c_DONE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready     = (r_state == c_IDLE);
        done      = (r_state == c_DONE);
        state_out = r_state;
        count_out = (r_state == c_CALC) ? r_count : '0;
    end

    assign p = r_p;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_mag_a  <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_p      <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_mag_a  <= w_abs_a;
                        r_b      <= w_abs_b;
                        r_signed <= signed_mode;
                        r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                c_CALC: begin
                    r_acc   <= r_acc + w_pp_shifted;
                    r_b     <= r_b >> DIGIT;
                    // Wrap to zero on the last digit so count reads 0 outside CALC.
                    r_count <= w_last ? '0 : r_count + CW'(1);
                end
                c_SIGN: begin
                    // p only changes here, on the SIGN->DONE edge.
                    r_p <= (r_signed && r_neg) ? -r_acc : r_acc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_multiplier_param
// Purpose  : Directed self-checking bench for seq_multiplier_param at the
//            default size (128/8) and two small variants (8/1 and 8/8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Default instance: WIDTH=128, DIGIT=8 (N=16)
    logic           start0, sm0;
    logic [127:0]   a0, b0;
    logic           ready0, done0;
    logic [255:0]   p0;
    logic [1:0]     st0;
    logic [3:0]     cnt0;

    // Small instances share operand inputs: WIDTH=8 with DIGIT=1 / DIGIT=8
    logic           start1, start2, sm_s;
    logic [7:0]     a_s, b_s;
    logic           ready1, done1, ready2, done2;
    logic [15:0]    p1, p2;
    logic [1:0]     st1, st2;
    logic [2:0]     cnt1;
    logic [0:0]     cnt2;

    seq_multiplier_param #(.WIDTH(128), .DIGIT(8)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .signed_mode(sm0),
        .a(a0), .b(b0), .ready(ready0), .p(p0), .done(done0),
        .state_out(st0), .count_out(cnt0)
    );

    seq_multiplier_param #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .signed_mode(sm_s),
        .a(a_s), .b(b_s), .ready(ready1), .p(p1), .done(done1),
        .state_out(st1), .count_out(cnt1)
    );

    seq_multiplier_param #(.WIDTH(8), .DIGIT(8)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .signed_mode(sm_s),
        .a(a_s), .b(b_s), .ready(ready2), .p(p2), .done(done2),
        .state_out(st2), .count_out(cnt2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // done and ready must never be high together
    always @(negedge clk) begin
        if (done0) chk("done_ready0", {255'd0, ready0}, 256'd0);
        if (done1) chk("done_ready1", {255'd0, ready1}, 256'd0);
        if (done2) chk("done_ready2", {255'd0, ready2}, 256'd0);
    end

    // Waits for ready, presents one request, returns at the negedge after
    // the accept edge with the cycle stamp of that edge.
    task automatic start_op0(input logic sm, input logic [127:0] a, input logic [127:0] b,
                             output int t_acc);
        int g;
        g = 0;
        @(negedge clk);
        while (!ready0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!ready0) chk("ready_timeout0", 256'd0, 256'd1);
        start0 = 1'b1;
        sm0    = sm;
        a0     = a;
        b0     = b;
        @(posedge clk);
        @(negedge clk);
        t_acc  = cyc;
        start0 = 1'b0;
        a0     = {$urandom, $urandom, $urandom, $urandom};
        b0     = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Latency = accept edge to the edge that samples done high.
    task automatic wait_done0(input int t_acc, input bit scramble, output int lat);
        int g;
        g = 0;
        while (!done0 && g < 200) begin
            if (scramble) begin
                a0  = {$urandom, $urandom, $urandom, $urandom};
                b0  = {$urandom, $urandom, $urandom, $urandom};
                sm0 = 1'($urandom);
            end
            @(negedge clk);
            g++;
        end
        if (!done0) begin
            chk("done_timeout0", 256'd0, 256'd1);
            lat = -1;
        end else begin
            lat = cyc - t_acc + 1;
        end
    endtask

    function automatic logic rdy_s(input int sel);
        return (sel == 1) ? ready1 : ready2;
    endfunction

    function automatic logic done_s(input int sel);
        return (sel == 1) ? done1 : done2;
    endfunction

    task automatic run_small(input int sel, input logic sm, input logic [7:0] a, input logic [7:0] b,
                             output logic [15:0] pr, output int lat);
        int g;
        int t;
        g = 0;
        @(negedge clk);
        while (!rdy_s(sel) && g < 100) begin
            @(negedge clk);
            g++;
        end
        sm_s = sm;
        a_s  = a;
        b_s  = b;
        if (sel == 1) start1 = 1'b1;
        else          start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t      = cyc;
        start1 = 1'b0;
        start2 = 1'b0;
        g      = 0;
        while (!done_s(sel) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!done_s(sel)) begin
            chk("done_timeout_small", 256'd0, 256'd1);
            lat = -1;
        end else begin
            lat = cyc - t + 1;
        end
        pr = (sel == 1) ? p1 : p2;
    endtask

    initial begin
        int            t;
        int            lat;
        int            g;
        int            nd;
        int            d1;
        logic [127:0]  ones;
        logic [127:0]  minv;
        logic [15:0]   ps;

        reset  = 1'b1;
        start0 = 1'b0; sm0 = 1'b0; a0 = '0; b0 = '0;
        start1 = 1'b0; start2 = 1'b0; sm_s = 1'b0; a_s = '0; b_s = '0;
        ones   = '1;
        minv   = 128'd1 << 127;

        // ---------------- reset from power-up ----------------
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_p",     p0,               256'd0);
        chk("rst_done",  {255'd0, done0},  256'd0);
        chk("rst_ready", {255'd0, ready0}, 256'd1);
        chk("rst_state", {254'd0, st0},    256'd0);
        chk("rst_count", {252'd0, cnt0},   256'd0);
        chk("rst_p1",    {240'd0, p1},     256'd0);
        chk("rst_state1", {254'd0, st1},   256'd0);
        chk("rst_count1", {253'd0, cnt1},  256'd0);
        chk("rst_count2", {255'd0, cnt2},  256'd0);
        chk("rst_state2", {254'd0, st2},   256'd0);
        reset = 1'b0;

        // ---------------- unsigned extremes ----------------
        start_op0(1'b0, ones, ones, t);
        for (int k = 0; k < 16; k++) begin
            chk("calc_count", {252'd0, cnt0}, 256'(k));
            chk("calc_state", {254'd0, st0},  256'd1);
            @(negedge clk);
        end
        chk("sign_state", {254'd0, st0},  256'd2);
        chk("sign_count", {252'd0, cnt0}, 256'd0);
        chk("p_held_sign", p0, 256'd0);
        wait_done0(t, 1'b0, lat);
        chk("ext_latency", 256'(lat), 256'd18);
        chk("ext_p_hi", {128'd0, p0[255:128]}, {128'd0, ~128'd1});
        chk("ext_p_lo", {128'd0, p0[127:0]},   256'd1);
        @(negedge clk);
        chk("after_done_ready", {255'd0, ready0}, 256'd1);
        chk("after_done_done",  {255'd0, done0},  256'd0);

        // ---------------- reset mid-operation ----------------
        start_op0(1'b0, 128'd11, 128'd13, t);
        g = 0;
        while (cnt0 != 4'd7 && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("reach_count7", {252'd0, cnt0}, 256'd7);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_state", {254'd0, st0},    256'd0);
        chk("midrst_p",     p0,               256'd0);
        chk("midrst_ready", {255'd0, ready0}, 256'd1);
        chk("midrst_count", {252'd0, cnt0},   256'd0);
        nd = 0;
        for (int k = 0; k < 25; k++) begin
            if (done0) nd++;
            @(negedge clk);
        end
        chk("midrst_no_done", 256'(nd), 256'd0);
        start_op0(1'b0, 128'd5, 128'd6, t);
        wait_done0(t, 1'b0, lat);
        chk("post_rst_p", p0, 256'd30);
        chk("post_rst_lat", 256'(lat), 256'd18);

        // ---------------- signed ----------------
        start_op0(1'b1, 128'd0 - 128'd3, 128'd7, t);
        wait_done0(t, 1'b0, lat);
        chk("s_m3x7", p0, 256'd0 - 256'd21);
        start_op0(1'b1, minv, minv, t);
        wait_done0(t, 1'b0, lat);
        chk("s_min_sq", p0, 256'd1 << 254);
        start_op0(1'b1, ones, 128'd0, t);
        wait_done0(t, 1'b0, lat);
        chk("s_m1x0", p0, 256'd0);

        // ---------------- handshake ----------------
        start_op0(1'b0, 128'd3, 128'd4, t);
        start0 = 1'b1;
        a0     = 128'd9;
        b0     = 128'd9;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0(t, 1'b0, lat);
        chk("ignored_start_p",   p0, 256'd12);
        chk("ignored_start_lat", 256'(lat), 256'd18);
        @(negedge clk);
        @(negedge clk);
        chk("no_queued_op", {254'd0, st0}, 256'd0);

        start_op0(1'b0, 128'd1000, 128'd1000, t);
        wait_done0(t, 1'b1, lat);
        chk("scramble_p", p0, 256'd1000000);

        // ---------------- back-to-back ----------------
        start_op0(1'b0, 128'd2, 128'd3, t);
        wait_done0(t, 1'b0, lat);
        chk("b2b_first_p", p0, 256'd6);
        d1 = cyc;
        start_op0(1'b0, 128'd4, 128'd5, t);
        chk("b2b_accept_gap", 256'(t - d1), 256'd2);
        chk("b2b_p_held", p0, 256'd6);
        wait_done0(t, 1'b0, lat);
        chk("b2b_second_p", p0, 256'd20);
        chk("b2b_done_gap", 256'(cyc - d1), 256'd19);

        // ---------------- parameter variants ----------------
        run_small(1, 1'b0, 8'd255, 8'd255, ps, lat);
        chk("w8d1_u_p",   {240'd0, ps}, 256'd65025);
        chk("w8d1_u_lat", 256'(lat),    256'd10);
        run_small(1, 1'b1, 8'hFF, 8'hFF, ps, lat);
        chk("w8d1_s_p",   {240'd0, ps}, 256'd1);
        chk("w8d1_s_lat", 256'(lat),    256'd10);
        run_small(2, 1'b0, 8'd200, 8'd3, ps, lat);
        chk("w8d8_u_p",   {240'd0, ps}, 256'd600);
        chk("w8d8_u_lat", 256'(lat),    256'd3);
        run_small(2, 1'b1, 8'h80, 8'h80, ps, lat);
        chk("w8d8_s_min", {240'd0, ps}, 256'd16384);
        run_small(2, 1'b1, 8'hFD, 8'd7, ps, lat);
        chk("w8d8_s_m3x7", {240'd0, ps}, 256'hFFEB);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
